// File: rtl/mc_eject_buf_pkg.sv
// Shared types and helpers for the local ejection buffer.
// Router-wide widths come from global.vh; these guarded values stand in when built alone.
`ifndef NUM_PORT
`define NUM_PORT 5
`endif
`ifndef DST_LIST_WIDTH
`define DST_LIST_WIDTH `NUM_PORT
`endif
`ifndef L_MASK
`define L_MASK 5'b10000
`endif

package mc_eject_buf_pkg;

  localparam int DST_W = `DST_LIST_WIDTH;
  localparam int NPORT = `NUM_PORT;

  localparam logic [DST_W-1:0] DST_L = `L_MASK;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Local delivery is done once the flit leaves through L.
  function automatic logic [DST_W-1:0] strip_local(
    input logic [DST_W-1:0] dst
  );
    return dst & ~DST_L;
  endfunction

endpackage

// File: rtl/mc_fifo_mem.sv
// Entry storage for the ejection buffer.
// One synchronous write port, one combinational read port.
module mc_fifo_mem
  import mc_eject_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the granted entry at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Head entry is read straight out of the array.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/mc_eject_buf.sv
// Local (L) port ejection buffer of the multicast BLESS router.
// Captures flits granted to L and drains them to the PE.
module mc_eject_buf
  import mc_eject_buf_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int FLIT_WIDTH = 128,
  parameter int CNT_WIDTH  = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  eject_vld,
  input  logic [FLIT_WIDTH-1:0] eject_flit,
  input  logic [DST_W-1:0]      eject_dst,
  output logic                  eject_avail,
  output logic                  pe_vld,
  output logic [FLIT_WIDTH-1:0] pe_flit,
  output logic [DST_W-1:0]      pe_dst,
  input  logic                  pe_rdy,
  output logic [CW-1:0]         occupancy,
  output logic                  ovf_err,
  output logic [CNT_WIDTH-1:0]  eject_cnt
);

  localparam int EW = FLIT_WIDTH + DST_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 avail_q, avail_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic          push, pop;
  fifo_op_e      op;
  logic [EW-1:0] rd_entry;

  mc_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({eject_flit, eject_dst}),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // Head view: valid from the count register only, no bypass.
  always_comb begin
    pe_vld  = (count_q != '0);
    pe_flit = rd_entry[EW-1:DST_W];
    pe_dst  = strip_local(rd_entry[DST_W-1:0]);
  end

  // A pop frees a slot in the same edge, so full+pop still accepts.
  always_comb begin
    pop  = pe_vld & pe_rdy;
    push = eject_vld & ((count_q < FULL) | pop);
    op   = fifo_op_e'({push, pop});
  end

  // Pointer, count, status and statistics next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case (op)
      OP_PUSH: count_d = count_q + CW'(1);
      OP_POP:  count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    avail_d = (count_d < FULL);
    ovf_d   = ovf_q | (eject_vld & ~push);
  end

  // State registers; reset drops every held entry at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      avail_q  <= 1'b1;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      avail_q  <= avail_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  // Status outputs come straight from flops.
  always_comb begin
    eject_avail = avail_q;
    occupancy   = count_q;
    ovf_err     = ovf_q;
    eject_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_mc_eject_buf.sv
// Directed bench for mc_eject_buf.
// Small flits and a 4-bit counter so saturation is reachable.
module tb_mc_eject_buf;
  import mc_eject_buf_pkg::*;

  localparam int DEPTH = 4;
  localparam int FW    = 16;
  localparam int CNTW  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            eject_vld;
  logic [FW-1:0]   eject_flit;
  logic [DST_W-1:0] eject_dst;
  logic            eject_avail;
  logic            pe_vld;
  logic [FW-1:0]   pe_flit;
  logic [DST_W-1:0] pe_dst;
  logic            pe_rdy;
  logic [CW-1:0]   occupancy;
  logic            ovf_err;
  logic [CNTW-1:0] eject_cnt;

  int checks = 0;
  int errors = 0;

  logic [DST_W-1:0] exp_dst;

  mc_eject_buf #(
    .DEPTH      (DEPTH),
    .FLIT_WIDTH (FW),
    .CNT_WIDTH  (CNTW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .eject_vld   (eject_vld),
    .eject_flit  (eject_flit),
    .eject_dst   (eject_dst),
    .eject_avail (eject_avail),
    .pe_vld      (pe_vld),
    .pe_flit     (pe_flit),
    .pe_dst      (pe_dst),
    .pe_rdy      (pe_rdy),
    .occupancy   (occupancy),
    .ovf_err     (ovf_err),
    .eject_cnt   (eject_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [FW-1:0] f,
                       input logic r);
    eject_vld  = v;
    eject_flit = f;
    pe_rdy     = r;
  endtask

  initial begin
    exp_dst    = ~DST_L;
    reset      = 1'b1;
    eject_vld  = 1'b0;
    eject_flit = '0;
    eject_dst  = 5'b00001;
    pe_rdy     = 1'b0;
    tick();
    tick();
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_vld", 32'(pe_vld), 0);
    chk("rst_avail", 32'(eject_avail), 1);
    chk("rst_ovf", 32'(ovf_err), 0);
    chk("rst_cnt", 32'(eject_cnt), 0);
    reset = 1'b0;

    // fill with A..D, PE stalled
    drive(1'b1, 16'hA, 1'b0);
    tick();
    chk("fill1_vld", 32'(pe_vld), 1);
    chk("fill1_head", 32'(pe_flit), 32'hA);
    chk("fill1_occ", 32'(occupancy), 1);
    drive(1'b1, 16'hB, 1'b0);
    tick();
    drive(1'b1, 16'hC, 1'b0);
    tick();
    chk("fill3_avail", 32'(eject_avail), 1);
    drive(1'b1, 16'hD, 1'b0);
    tick();
    chk("fill4_avail", 32'(eject_avail), 0);
    chk("fill4_occ", 32'(occupancy), 4);
    chk("fill4_head", 32'(pe_flit), 32'hA);

    // full with simultaneous push/pop
    drive(1'b1, 16'hF, 1'b1);
    tick();
    chk("both_occ", 32'(occupancy), 4);
    chk("both_head", 32'(pe_flit), 32'hB);
    chk("both_ovf", 32'(ovf_err), 0);
    chk("both_avail", 32'(eject_avail), 0);

    // overflow drop
    drive(1'b1, 16'hE, 1'b0);
    tick();
    chk("ovf_flag", 32'(ovf_err), 1);
    chk("ovf_occ", 32'(occupancy), 4);
    chk("ovf_head", 32'(pe_flit), 32'hB);
    drive(1'b0, 16'h0, 1'b0);
    tick();
    chk("ovf_sticky", 32'(ovf_err), 1);
    chk("stall_head", 32'(pe_flit), 32'hB);

    // drain: B, C, D, F (E never appears)
    drive(1'b0, 16'h0, 1'b1);
    tick();
    chk("drain_c", 32'(pe_flit), 32'hC);
    chk("drain_avail", 32'(eject_avail), 1);
    tick();
    chk("drain_d", 32'(pe_flit), 32'hD);
    tick();
    chk("drain_f", 32'(pe_flit), 32'hF);
    chk("drain_occ1", 32'(occupancy), 1);
    tick();
    chk("empty_vld", 32'(pe_vld), 0);
    chk("empty_occ", 32'(occupancy), 0);
    chk("cnt5", 32'(eject_cnt), 5);

    // asynchronous reset with three entries held
    drive(1'b1, 16'h11, 1'b0);
    tick();
    tick();
    tick();
    chk("pre_rst_occ", 32'(occupancy), 3);
    drive(1'b0, 16'h0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_occ", 32'(occupancy), 0);
    chk("arst_vld", 32'(pe_vld), 0);
    chk("arst_avail", 32'(eject_avail), 1);
    chk("arst_ovf", 32'(ovf_err), 0);
    chk("arst_cnt", 32'(eject_cnt), 0);
    tick();
    reset = 1'b0;

    // wrap: 10 push/pop pairs, all-ones dst
    eject_dst = '1;
    drive(1'b1, 16'h100, 1'b0);
    tick();
    for (int i = 1; i < 10; i++) begin
      drive(1'b1, 16'(16'h100 + i), 1'b1);
      chk("wrap_head", 32'(pe_flit), 32'(16'h100 + i - 1));
      chk("wrap_dst", 32'(pe_dst), 32'(exp_dst));
      tick();
      chk("wrap_occ", 32'(occupancy), 1);
    end
    drive(1'b0, 16'h0, 1'b1);
    chk("wrap_last", 32'(pe_flit), 32'h109);
    chk("wrap_ldst", 32'(pe_dst), 32'(exp_dst));
    tick();
    chk("wrap_empty", 32'(pe_vld), 0);
    chk("wrap_cnt", 32'(eject_cnt), 10);

    // saturation: 10 more pushes reach 20 total
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'(16'h200 + i), 1'b1);
      tick();
    end
    drive(1'b0, 16'h0, 1'b0);
    chk("sat_cnt", 32'(eject_cnt), 15);
    tick();
    chk("sat_hold", 32'(eject_cnt), 15);
    chk("sat_head", 32'(pe_flit), 32'h209);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
